// File: rtl/mpu_control_fsm.sv
// Multicycle fetch/decode/execute controller for the 8-bit MPU.
// Moore outputs decoded from the registered state and the current IR.
module mpu_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       enter,
  output logic       IRload,
  output logic       MRload,
  output logic [1:0] JMPmux,
  output logic       PCload,
  output logic       MemInst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       RFwr,
  output logic [2:0] ALUsel,
  output logic [1:0] Shiftsel,
  output logic       outen,
  output logic       waiting,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ADDR,
    S_IMM,
    S_INWAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0] op;
  logic       is_ldm;
  logic       is_stm;
  logic       is_mem;
  logic       is_jmp;
  logic       is_jz;
  logic       is_jp;
  logic       is_ldi;
  logic       is_in;
  logic       is_halt;
  logic       taken;

  assign op      = IR[7:4];
  assign is_ldm  = (op == 4'b0010);
  assign is_stm  = (op == 4'b0011);
  assign is_mem  = is_ldm | is_stm;
  assign is_jmp  = (op == 4'b1010);
  assign is_jz   = (op == 4'b1011);
  assign is_jp   = (op == 4'b1100);
  assign is_ldi  = (op == 4'b0100);
  assign is_in   = (op == 4'b1110);
  assign is_halt = (IR == 8'hF1);

  // Conditions read A as left by the previous instruction.
  assign taken = is_jmp
               | (is_jz & Aeq0)
               | (is_jp & Apos);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem,
          is_jmp,
          is_jz,
          is_jp:   state_d = S_ADDR;
          is_ldi:  state_d = S_IMM;
          is_in:   state_d = S_INWAIT;
          is_halt: state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_ADDR: begin
        state_d = is_mem ? S_EXEC : S_FETCH;
      end
      S_IMM:    state_d = S_FETCH;
      S_INWAIT: begin
        state_d = enter ? S_FETCH : S_INWAIT;
      end
      S_EXEC:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IRload   = 1'b0;
    MRload   = 1'b0;
    JMPmux   = 2'b00;
    PCload   = 1'b0;
    MemInst  = 1'b0;
    MemWr    = 1'b0;
    Asel     = 2'b00;
    Aload    = 1'b0;
    RFwr     = 1'b0;
    ALUsel   = 3'b000;
    Shiftsel = 2'b00;
    outen    = 1'b0;
    waiting  = 1'b0;
    halted   = 1'b0;
    // Gate with reset so nothing is strobed while reset is held.
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          IRload = 1'b1;
          PCload = 1'b1;
        end
        S_DECODE: begin
        end
        S_ADDR: begin
          MRload = is_mem;
          PCload = 1'b1;
          JMPmux = taken ? 2'b01 : 2'b00;
        end
        S_IMM: begin
          Asel   = 2'b11;
          Aload  = 1'b1;
          PCload = 1'b1;
        end
        S_INWAIT: begin
          waiting = 1'b1;
          if (enter) begin
            Asel  = 2'b10;
            Aload = 1'b1;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        S_EXEC: begin
          unique case (op)
            4'b0000: begin
              Asel  = 2'b01;
              Aload = 1'b1;
            end
            4'b0001: RFwr = 1'b1;
            4'b0010: begin
              MemInst = 1'b1;
              Asel    = 2'b11;
              Aload   = 1'b1;
            end
            4'b0011: begin
              MemInst = 1'b1;
              MemWr   = 1'b1;
            end
            4'b0101: begin
              ALUsel = 3'b100;
              Aload  = 1'b1;
            end
            4'b0110: begin
              ALUsel = 3'b101;
              Aload  = 1'b1;
            end
            4'b0111: begin
              ALUsel = 3'b001;
              Aload  = 1'b1;
            end
            4'b1000: begin
              ALUsel = 3'b010;
              Aload  = 1'b1;
            end
            4'b1001: begin
              ALUsel = IR[3] ? 3'b111 : 3'b110;
              Aload  = 1'b1;
            end
            4'b1101: begin
              PCload = 1'b1;
              JMPmux = IR[3] ? 2'b10 : 2'b11;
            end
            4'b1111: begin
              unique case (IR[3:0])
                4'b0000: outen = 1'b1;
                4'b0010: begin
                  ALUsel = 3'b011;
                  Aload  = 1'b1;
                end
                4'b0011: begin
                  Shiftsel = 2'b01;
                  Aload    = 1'b1;
                end
                4'b0100: begin
                  Shiftsel = 2'b10;
                  Aload    = 1'b1;
                end
                4'b0101: begin
                  Shiftsel = 2'b11;
                  Aload    = 1'b1;
                end
                default: begin
                end
              endcase
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_control_fsm.sv
// Bench for mpu_control_fsm: directed and random instructions
// checked cycle by cycle against a per-instruction trace model.
module tb_mpu_control_fsm;

  typedef struct packed {
    logic       irl;
    logic       mrl;
    logic [1:0] jmp;
    logic       pcl;
    logic       mi;
    logic       mw;
    logic [1:0] asel;
    logic       al;
    logic       rfw;
    logic [2:0] alu;
    logic [1:0] sh;
    logic       oe;
    logic       wt;
    logic       hl;
  } ov_t;

  logic       clk;
  logic       reset;
  logic [7:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       enter;
  logic       IRload;
  logic       MRload;
  logic [1:0] JMPmux;
  logic       PCload;
  logic       MemInst;
  logic       MemWr;
  logic [1:0] Asel;
  logic       Aload;
  logic       RFwr;
  logic [2:0] ALUsel;
  logic [1:0] Shiftsel;
  logic       outen;
  logic       waiting;
  logic       halted;

  ov_t  obs;
  ov_t  exp_q[$];
  logic en_q[$];
  int   n_cmp;
  int   n_err;

  mpu_control_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .IR       (IR),
    .Aeq0     (Aeq0),
    .Apos     (Apos),
    .enter    (enter),
    .IRload   (IRload),
    .MRload   (MRload),
    .JMPmux   (JMPmux),
    .PCload   (PCload),
    .MemInst  (MemInst),
    .MemWr    (MemWr),
    .Asel     (Asel),
    .Aload    (Aload),
    .RFwr     (RFwr),
    .ALUsel   (ALUsel),
    .Shiftsel (Shiftsel),
    .outen    (outen),
    .waiting  (waiting),
    .halted   (halted)
  );

  assign obs = {IRload, MRload, JMPmux, PCload, MemInst, MemWr,
                Asel, Aload, RFwr, ALUsel, Shiftsel, outen,
                waiting, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input ov_t exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ov_t exec_vec(input logic [7:0] ir);
    ov_t v;
    v = '0;
    case (ir[7:4])
      4'h0: begin v.asel = 2'b01; v.al = 1'b1; end
      4'h1: v.rfw = 1'b1;
      4'h5: begin v.alu = 3'b100; v.al = 1'b1; end
      4'h6: begin v.alu = 3'b101; v.al = 1'b1; end
      4'h7: begin v.alu = 3'b001; v.al = 1'b1; end
      4'h8: begin v.alu = 3'b010; v.al = 1'b1; end
      4'h9: begin v.alu = ir[3] ? 3'b111 : 3'b110; v.al = 1'b1; end
      4'hD: begin v.pcl = 1'b1; v.jmp = ir[3] ? 2'b10 : 2'b11; end
      4'hF: begin
        case (ir[3:0])
          4'h0: v.oe = 1'b1;
          4'h2: begin v.alu = 3'b011; v.al = 1'b1; end
          4'h3: begin v.sh = 2'b01; v.al = 1'b1; end
          4'h4: begin v.sh = 2'b10; v.al = 1'b1; end
          4'h5: begin v.sh = 2'b11; v.al = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return v;
  endfunction

  // Full cycle-by-cycle output trace of one instruction.
  task automatic build(input logic [7:0] ir, input logic z,
                       input logic p, input int nw);
    ov_t v;
    logic [3:0] op;
    op = ir[7:4];
    exp_q.delete();
    en_q.delete();
    v = '0; v.irl = 1'b1; v.pcl = 1'b1;
    exp_q.push_back(v); en_q.push_back(1'b0);
    v = '0;
    exp_q.push_back(v); en_q.push_back(1'b0);
    if (ir == 8'hF1) begin
      v = '0; v.hl = 1'b1;
      repeat (10) begin
        exp_q.push_back(v); en_q.push_back(1'b0);
      end
    end else if (op == 4'h2 || op == 4'h3) begin
      v = '0; v.mrl = 1'b1; v.pcl = 1'b1;
      exp_q.push_back(v); en_q.push_back(1'b0);
      v = '0; v.mi = 1'b1;
      if (op == 4'h2) begin v.asel = 2'b11; v.al = 1'b1; end
      else v.mw = 1'b1;
      exp_q.push_back(v); en_q.push_back(1'b0);
    end else if (op >= 4'hA && op <= 4'hC) begin
      v = '0; v.pcl = 1'b1;
      if (op == 4'hA || (op == 4'hB && z) || (op == 4'hC && p))
        v.jmp = 2'b01;
      exp_q.push_back(v); en_q.push_back(1'b0);
    end else if (op == 4'h4) begin
      v = '0; v.asel = 2'b11; v.al = 1'b1; v.pcl = 1'b1;
      exp_q.push_back(v); en_q.push_back(1'b0);
    end else if (op == 4'hE) begin
      v = '0; v.wt = 1'b1;
      repeat (nw) begin
        exp_q.push_back(v); en_q.push_back(1'b0);
      end
      v.asel = 2'b10; v.al = 1'b1;
      exp_q.push_back(v); en_q.push_back(1'b1);
    end else begin
      exp_q.push_back(exec_vec(ir)); en_q.push_back(1'b0);
    end
  endtask

  // Entered just after the edge that starts FETCH; leaves at the next one.
  task automatic run(input string nm, input logic [7:0] ir,
                     input logic z, input logic p, input int nw);
    build(ir, z, p, nw);
    Aeq0 = z;
    Apos = p;
    foreach (exp_q[i]) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i == 1) IR = ir;
      enter = en_q[i];
      @(negedge clk);
      check($sformatf("%s_%h_c%0d", nm, ir, i), exp_q[i]);
    end
    @(posedge clk); #1;
    enter = 1'b0;
  endtask

  initial begin
    ov_t zero;
    logic [7:0] r;
    zero  = '0;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    IR    = 8'hF1;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
    enter = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_idle", zero);
    @(posedge clk); #1;
    reset = 1'b1;

    run("add",  8'h53, 1'b0, 1'b0, 0);
    run("add2", 8'h53, 1'b1, 1'b1, 0);
    run("jz_t", 8'hB0, 1'b1, 1'b0, 0);
    run("jz_n", 8'hB0, 1'b0, 1'b1, 0);
    run("jp_t", 8'hC0, 1'b0, 1'b1, 0);
    run("jp_n", 8'hC0, 1'b1, 1'b0, 0);
    run("jmp",  8'hA3, 1'b0, 1'b0, 0);
    run("ldm",  8'h20, 1'b0, 1'b0, 0);
    run("stm",  8'h30, 1'b0, 1'b0, 0);
    run("ldi",  8'h40, 1'b0, 1'b0, 0);
    run("in5",  8'hE0, 1'b0, 1'b0, 5);
    run("in0",  8'hE0, 1'b0, 1'b0, 0);
    run("jrf",  8'hD5, 1'b0, 1'b0, 0);
    run("jrb",  8'hDD, 1'b0, 1'b0, 0);
    run("out",  8'hF0, 1'b0, 1'b0, 0);
    run("rotr", 8'hF5, 1'b0, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      r = 8'($urandom_range(0, 255));
      if (r == 8'hF1) r = 8'hF2;
      run("rnd", r, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Abort an ADD in its EXEC cycle.
    build(8'h53, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("abort_fetch", exp_q[0]);
    @(posedge clk); #1;
    IR = 8'h53;
    @(posedge clk); #1;
    check("abort_exec", exp_q[2]);
    reset = 1'b0;
    #1;
    check("abort_drop", zero);
    @(negedge clk);
    check("abort_hold", zero);
    @(posedge clk); #1;
    reset = 1'b1;
    run("post_rst", 8'h95, 1'b0, 1'b0, 0);

    run("halt", 8'hF1, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mpu_control_fsm.md
Name: mpu_control_fsm

Overview:
- Multicycle control unit for the 8-bit MPU; sits directly upstream of the datapath.
- Consumes IR[7:0], Aeq0 and Apos from the datapath.
- Drives every datapath load, select and write strobe through a fetch/decode/execute state machine.
- Also provides an input-wait handshake and a halt indicator.

Parameters:
- none (encodings below are fixed by the datapath)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- IR  input  8  current instruction register from datapath
- Aeq0  input  1  accumulator == 0
- Apos  input  1  accumulator bit 7 == 0
- enter  input  1  user input valid
- IRload  output  1  load instruction register
- MRload  output  1  load memory-address register
- JMPmux  output  2  next-PC select: 00 PC+1, 01 ram[5:0], 10 PC-IR[2:0], 11 PC+IR[2:0]
- PCload  output  1  load PC
- MemInst  output  1  RAM address select: 0 PC, 1 MR
- MemWr  output  1  RAM write
- Asel  output  2  A source: 00 shifter, 01 regfile, 10 in, 11 ram
- Aload  output  1  load accumulator
- RFwr  output  1  write R[IR[2:0]] from A
- ALUsel  output  3  000 pass A, 001 AND, 010 OR, 011 NOT A, 100 ADD, 101 SUB, 110 INC, 111 DEC
- Shiftsel  output  2  00 pass, 01 shl, 10 shr, 11 rotr
- outen  output  1  load output register
- waiting  output  1  high while stalled for enter
- halted  output  1  high in HALT

Behaviour:
- Outputs are Moore-style, decoded from the registered state and IR. Any strobe not listed for a state is 0; unlisted selects are 00/000.
- While reset=0 (asynchronous, active-low), state=FETCH is forced and all strobes, waiting and halted are 0.
- FETCH: IRload=1, PCload=1, JMPmux=00, MemInst=0 → DECODE.
- DECODE: no strobes. Routing by IR[7:4]:
  - two-byte opcodes (0010, 0011, 1010, 1011, 1100) → ADDR
  - 0100 → IMM
  - 1110 → INWAIT
  - 1111/0001 → HALT
  - all others → EXEC
- ADDR: MRload=1 for LDM/STM; PCload=1 always.
  - JMP: JMPmux=01 (taken).
  - JZ: JMPmux=01 if Aeq0, else 00.
  - JP: JMPmux=01 if Apos, else 00.
  - Next state: LDM/STM → EXEC; jumps → FETCH.
- IMM: MemInst=0, Asel=11, Aload=1, PCload=1, JMPmux=00 → FETCH.
- INWAIT: waiting=1. If enter=1: Asel=10, Aload=1 → FETCH; else stay in INWAIT.
- HALT: halted=1, absorbing until reset.
- EXEC (1 cycle, then → FETCH), by IR[7:4]:
  - 0000 LDA: Asel=01, Aload=1
  - 0001 STA: RFwr=1
  - 0010 LDM: MemInst=1, Asel=11, Aload=1
  - 0011 STM: MemInst=1, MemWr=1
  - 0101 ADD / 0110 SUB / 0111 AND / 1000 OR: ALUsel=100/101/001/010, Asel=00, Aload=1
  - 1001: IR[3]=0 INC (110), IR[3]=1 DEC (111), Asel=00, Aload=1
  - 1101 JR: PCload=1; JMPmux=11 if IR[3]=0, else 10
  - 1111 sub-ops on IR[3:0]:
    - 0000 OUT: outen=1
    - 0010 NOT: ALUsel=011, Asel=00, Aload=1
    - 0011/0100/0101 SHL/SHR/ROTR: ALUsel=000, Shiftsel=01/10/11, Asel=00, Aload=1
    - others: NOP
- Latency:
  - single-byte instructions: 3 cycles
  - LDI, IN with enter already high, JMP/JZ/JP: 3 cycles
  - LDM/STM: 4 cycles
- Relative jump offsets apply to the PC already incremented past the opcode.
- PC width is 6 bits, so wrap at 63→0 is the datapath's concern; the FSM makes no special case for it.
- Conditions are sampled in the ADDR cycle itself, so the A value is the one left by the prior instruction.
- Reset asserted mid-instruction aborts it; no strobe may remain high after reset assertion.

Test Plan:
- Reset low then release, IR=8'hF1 → one FETCH cycle (IRload=PCload=1), DECODE, then halted=1 held for ≥10 cycles; no further IRload.
- IR=8'h53 (ADD R3) → EXEC cycle shows ALUsel=100, Asel=00, Aload=1, Shiftsel=00; IRload pulses every 3 cycles.
- IR=8'hB0 (JZ), Aeq0=1 → ADDR cycle has PCload=1, JMPmux=01; repeat with Aeq0=0 → JMPmux=00, and FETCH follows in both cases.
- IR=8'h20 (LDM) → ADDR: MRload=1, PCload=1; EXEC: MemInst=1, Asel=11, Aload=1; IR=8'h30 (STM) EXEC: MemWr=1, MemInst=1, Aload=0.
- IR=8'hE0 (IN), enter held 0 for 5 cycles then 1 → waiting=1 for those 5 cycles; Aload=1 with Asel=10 exactly in the enter cycle; then FETCH.
- IR=8'hD5 → JMPmux=11; IR=8'hDD → JMPmux=10. Assert reset low during EXEC → all strobes drop immediately; state returns to FETCH after release.
